// File: rtl/avalon_pio_debounced.sv
// Avalon-MM PIO for buttons and LEDs: 2-FF input sync, per-bit debounce,
// rise/fall edge capture with IRQ mask, and atomic output set/clear.
module avalon_pio_debounced #(
   parameter int unsigned IN_WIDTH        = 8,
   parameter int unsigned OUT_WIDTH       = 8,
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned CNT_W           = 16,
   parameter logic [31:0] OUT_RESET       = '0
) (
   input  logic                 clk_clk,
   input  logic                 reset_reset_n,
   input  logic [2:0]           avs_address,
   input  logic                 avs_read,
   input  logic                 avs_write,
   input  logic [31:0]          avs_writedata,
   output logic [31:0]          avs_readdata,
   output logic                 irq,
   input  logic [IN_WIDTH-1:0]  button_export,
   output logic [OUT_WIDTH-1:0] led_export
);

   typedef enum logic [2:0] {
      A_DATA     = 3'd0,
      A_OUT      = 3'd1,
      A_IRQ_MASK = 3'd2,
      A_EDGE_CAP = 3'd3,
      A_OUT_SET  = 3'd4,
      A_OUT_CLR  = 3'd5,
      A_RISE_EN  = 3'd6,
      A_FALL_EN  = 3'd7
   } reg_addr_e;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [IN_WIDTH-1:0]  sync1_q, sync1_d;
   logic [IN_WIDTH-1:0]  sync2_q, sync2_d;
   logic [IN_WIDTH-1:0]  stable_q, stable_d;
   logic [IN_WIDTH-1:0]  stable_prev_q, stable_prev_d;
   logic [CNT_W-1:0]     cnt_q [IN_WIDTH];
   logic [CNT_W-1:0]     cnt_d [IN_WIDTH];
   logic [IN_WIDTH-1:0]  edge_cap_q, edge_cap_d;
   logic [IN_WIDTH-1:0]  irq_mask_q, irq_mask_d;
   logic [IN_WIDTH-1:0]  rise_en_q, rise_en_d;
   logic [IN_WIDTH-1:0]  fall_en_q, fall_en_d;
   logic [OUT_WIDTH-1:0] out_q, out_d;
   logic [31:0]          readdata_q, readdata_d;

   logic [IN_WIDTH-1:0]  rise, fall, w1c;
   logic [IN_WIDTH-1:0]  wdata_in;
   logic [OUT_WIDTH-1:0] wdata_out;
   logic [31:0]          rd_mux;
   reg_addr_e            addr;
   logic                 unused_wdata;

   // Debounce: a bit only adopts the synced level after it differs from
   // stable for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts.
   always_comb begin
      sync1_d       = button_export;
      sync2_d       = sync1_q;
      stable_d      = stable_q;
      stable_prev_d = stable_q;
      cnt_d         = cnt_q;
      for (int unsigned i = 0; i < IN_WIDTH; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               stable_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      addr         = reg_addr_e'(avs_address);
      wdata_in     = avs_writedata[IN_WIDTH-1:0];
      wdata_out    = avs_writedata[OUT_WIDTH-1:0];
      unused_wdata = ^avs_writedata;
      rise         = stable_q & ~stable_prev_q;
      fall         = ~stable_q & stable_prev_q;
      w1c          = (avs_write && addr == A_EDGE_CAP) ? wdata_in : '0;
      // A new edge in the same cycle as its W1C keeps the bit set.
      edge_cap_d   = (edge_cap_q & ~w1c) | (rise & rise_en_q) | (fall & fall_en_q);
      out_d        = out_q;
      irq_mask_d   = irq_mask_q;
      rise_en_d    = rise_en_q;
      fall_en_d    = fall_en_q;
      if (avs_write) begin
         case (addr)
            A_OUT:      out_d      = wdata_out;
            A_IRQ_MASK: irq_mask_d = wdata_in;
            A_OUT_SET:  out_d      = out_q | wdata_out;
            A_OUT_CLR:  out_d      = out_q & ~wdata_out;
            A_RISE_EN:  rise_en_d  = wdata_in;
            A_FALL_EN:  fall_en_d  = wdata_in;
            default:    ;
         endcase
      end
   end

   always_comb begin
      rd_mux = '0;
      case (addr)
         A_DATA:     rd_mux[IN_WIDTH-1:0]  = stable_q;
         A_OUT:      rd_mux[OUT_WIDTH-1:0] = out_q;
         A_IRQ_MASK: rd_mux[IN_WIDTH-1:0]  = irq_mask_q;
         A_EDGE_CAP: rd_mux[IN_WIDTH-1:0]  = edge_cap_q;
         A_RISE_EN:  rd_mux[IN_WIDTH-1:0]  = rise_en_q;
         A_FALL_EN:  rd_mux[IN_WIDTH-1:0]  = fall_en_q;
         default:    rd_mux = '0;
      endcase
      readdata_d = avs_read ? rd_mux : readdata_q;
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         sync1_q       <= '0;
         sync2_q       <= '0;
         stable_q      <= '0;
         stable_prev_q <= '0;
         for (int unsigned i = 0; i < IN_WIDTH; i++) cnt_q[i] <= '0;
         edge_cap_q    <= '0;
         irq_mask_q    <= '0;
         rise_en_q     <= '0;
         fall_en_q     <= '0;
         out_q         <= OUT_RESET[OUT_WIDTH-1:0];
         readdata_q    <= '0;
      end else begin
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         stable_q      <= stable_d;
         stable_prev_q <= stable_prev_d;
         cnt_q         <= cnt_d;
         edge_cap_q    <= edge_cap_d;
         irq_mask_q    <= irq_mask_d;
         rise_en_q     <= rise_en_d;
         fall_en_q     <= fall_en_d;
         out_q         <= out_d;
         readdata_q    <= readdata_d;
      end
   end

   always_comb begin
      avs_readdata = readdata_q;
      led_export   = out_q;
      irq          = |(edge_cap_q & irq_mask_q);
   end

endmodule
